// File: rtl/lcd_result_formatter_if.sv
// lcd_result_formatter_if: transaction and character-bus bundle between the
// multiplier side, the result formatter and the LCD driver.
//   iA, iB    16-bit operands to display in hex
//   iResult   32-bit product to display in decimal
//   iStart    request, taken when oBusy is low
//   oBusy     frame under construction
//   oDone     one-cycle pulse when oChars has just been refreshed
//   oChars    32 ASCII characters, char 0 in the top byte
// master drives the request side; slave is the formatter.
interface lcd_result_formatter_if;
  logic [15:0]  iA;
  logic [15:0]  iB;
  logic [31:0]  iResult;
  logic         iStart;
  logic         oBusy;
  logic         oDone;
  logic [255:0] oChars;

  modport master (
    output iA, iB, iResult, iStart,
    input  oBusy, oDone, oChars
  );

  modport slave (
    input  iA, iB, iResult, iStart,
    output oBusy, oDone, oChars
  );
endinterface

// File: rtl/lcd_result_formatter.sv
// lcd_result_formatter: builds the two-line, 32-character LCD frame
//   line 1: "A=hhhh B=hhhh   "   operands in uppercase hex
//   line 2: "R=dddddddddd    "   product in right-justified unsigned decimal
// The product is converted to BCD with double-dabble, one bit per cycle, and the
// whole frame is written to the output register in a single cycle so the LCD
// driver never samples a half-built frame.
// Ports:
//   Clock  system clock, rising edge
//   Reset  asynchronous active-low reset
//   bus    slave side of lcd_result_formatter_if (request in, frame out)
module lcd_result_formatter (
  input logic                   Clock,
  input logic                   Reset,
  lcd_result_formatter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StConvert, StEmit} state_e;

  localparam logic [255:0] AllSpaces = {32{8'h20}};

  state_e        state_q, state_d;
  logic [15:0]   a_q, a_d;
  logic [15:0]   b_q, b_d;
  logic [39:0]   bcd_q, bcd_d;
  logic [31:0]   sr_q, sr_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [255:0]  chars_q, chars_d;
  logic          done_q, done_d;
  logic [39:0]   bcd_adj;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [255:0] build_frame(input logic [15:0] a, input logic [15:0] b,
                                               input logic [39:0] bcd);
    logic [7:0]   ch [32];
    logic         seen;
    logic [3:0]   d;
    logic [255:0] f;
    for (int k = 0; k < 32; k++) ch[k] = 8'h20;
    ch[0]  = 8'h41;  // 'A'
    ch[1]  = 8'h3D;  // '='
    ch[7]  = 8'h42;  // 'B'
    ch[8]  = 8'h3D;
    for (int i = 0; i < 4; i++) begin
      ch[2 + i] = hex_char(a[15 - 4 * i -: 4]);
      ch[9 + i] = hex_char(b[15 - 4 * i -: 4]);
    end
    ch[16] = 8'h52;  // 'R'
    ch[17] = 8'h3D;
    // Blank leading zeros from the most significant digit down; the units digit
    // is always shown so a zero result reads "0".
    seen = 1'b0;
    for (int j = 9; j >= 1; j--) begin
      d = bcd[4 * j +: 4];
      if (d != 4'd0) seen = 1'b1;
      ch[27 - j] = seen ? {4'h3, d} : 8'h20;
    end
    ch[27] = {4'h3, bcd[3:0]};
    f = '0;
    for (int k = 0; k < 32; k++) f[255 - 8 * k -: 8] = ch[k];
    return f;
  endfunction

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4 * i +: 4] >= 4'd5) bcd_adj[4 * i +: 4] = bcd_q[4 * i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    bcd_d   = bcd_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    chars_d = chars_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.iStart) begin
          a_d     = bus.iA;
          b_d     = bus.iB;
          bcd_d   = '0;
          sr_d    = bus.iResult;
          cnt_d   = '0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        {bcd_d, sr_d} = {bcd_adj[38:0], sr_q, 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = StEmit;
      end
      StEmit: begin
        chars_d = build_frame(a_q, b_q, bcd_q);
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      bcd_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      chars_q <= AllSpaces;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bcd_q   <= bcd_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      chars_q <= chars_d;
      done_q  <= done_d;
    end
  end

  assign bus.oBusy  = (state_q != StIdle);
  assign bus.oDone  = done_q;
  assign bus.oChars = chars_q;

endmodule

// File: tb/tb_lcd_result_formatter.sv
module tb_lcd_result_formatter;

  logic Clock;
  logic Reset;
  int   vectors;
  int   miscompares;

  localparam logic [255:0] Spaces = {32{8'h20}};

  lcd_result_formatter_if bus ();

  lcd_result_formatter dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference: frame text from plain arithmetic (nibble lookup, repeated /10).
  function automatic logic [255:0] model_frame(input logic [15:0] a, input logic [15:0] b,
                                               input logic [31:0] r);
    logic [7:0]   c [32];
    logic [255:0] f;
    longint unsigned v;
    int n;
    for (int k = 0; k < 32; k++) c[k] = 8'h20;
    c[0] = "A"; c[1] = "="; c[7] = "B"; c[8] = "="; c[16] = "R"; c[17] = "=";
    for (int i = 0; i < 4; i++) begin
      n = (int'(a) >> (12 - 4 * i)) & 15;
      c[2 + i] = 8'(n < 10 ? 48 + n : 55 + n);
      n = (int'(b) >> (12 - 4 * i)) & 15;
      c[9 + i] = 8'(n < 10 ? 48 + n : 55 + n);
    end
    v = longint'(r);
    for (int pos = 27; pos >= 18; pos--) begin
      if (pos == 27 || v != 0) c[pos] = 8'(48 + (v % 10));
      v = v / 10;
    end
    f = '0;
    for (int k = 0; k < 32; k++) f[255 - 8 * k -: 8] = c[k];
    return f;
  endfunction

  // Drive one request; returns at the first negedge after the accepting edge,
  // with the inputs scrambled to show they are no longer needed.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [31:0] r);
    @(negedge Clock);
    bus.iA = a; bus.iB = b; bus.iResult = r; bus.iStart = 1'b1;
    @(negedge Clock);
    bus.iStart = 1'b0;
    bus.iA = 16'($urandom); bus.iB = 16'($urandom); bus.iResult = $urandom;
  endtask

  // Bounded wait for oDone, sampled on negedges; n = negedges waited or -1.
  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge Clock);
      if (bus.oDone === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    bus.iStart = 1'b0; bus.iA = '0; bus.iB = '0; bus.iResult = '0;
    repeat (3) @(negedge Clock);
    vectors++;
    if (bus.oChars !== Spaces) begin
      miscompares++; $display("FAIL reset_chars: got %h want %h", bus.oChars, Spaces);
    end
    vectors++;
    if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got busy=%b done=%b want 0 0", bus.oBusy, bus.oDone);
    end
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      vectors++;
      if (bus.oChars !== Spaces || bus.oBusy !== 1'b0 || bus.oDone !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_hold: got busy=%b done=%b chars=%h want 0 0 spaces",
                 bus.oBusy, bus.oDone, bus.oChars);
      end
    end
  endtask

  task automatic test_directed;
    logic [15:0]  ta [4];
    logic [15:0]  tb [4];
    logic [31:0]  tr [4];
    logic [255:0] lit [4];
    int n;
    ta[0] = 16'h1234; tb[0] = 16'h00FF; tr[0] = 32'd1188300;
    lit[0] = "A=1234 B=00FF   R=   1188300    ";
    ta[1] = 16'h0000; tb[1] = 16'h0000; tr[1] = 32'd0;
    lit[1] = "A=0000 B=0000   R=         0    ";
    ta[2] = 16'hFFFF; tb[2] = 16'hFFFF; tr[2] = 32'hFFFE0001;
    lit[2] = "A=FFFF B=FFFF   R=4294836225    ";
    ta[3] = 16'hFFFF; tb[3] = 16'hFFFF; tr[3] = 32'hFFFFFFFF;
    lit[3] = "A=FFFF B=FFFF   R=4294967295    ";
    for (int t = 0; t < 4; t++) begin
      launch(ta[t], tb[t], tr[t]);
      vectors++;
      if (bus.oBusy !== 1'b1) begin
        miscompares++; $display("FAIL dir_busy[%0d]: got %b want 1", t, bus.oBusy);
      end
      wait_done(60, n);
      vectors++;
      if (n != 33) begin
        miscompares++; $display("FAIL dir_latency[%0d]: got %0d want 33", t, n);
      end
      vectors++;
      if (bus.oChars !== lit[t]) begin
        miscompares++; $display("FAIL dir_chars[%0d]: got %h want %h", t, bus.oChars, lit[t]);
      end
      vectors++;
      if (bus.oChars !== model_frame(ta[t], tb[t], tr[t])) begin
        miscompares++;
        $display("FAIL dir_model[%0d]: got %h want %h", t, bus.oChars,
                 model_frame(ta[t], tb[t], tr[t]));
      end
    end
  endtask

  task automatic test_random;
    logic [15:0]  a, b;
    logic [31:0]  r;
    logic [255:0] exp;
    int n;
    for (int t = 0; t < 10; t++) begin
      a = 16'($urandom); b = 16'($urandom); r = $urandom;
      if (t == 0) r = 32'd7;
      if (t == 1) r = 32'd1000000000;
      exp = model_frame(a, b, r);
      launch(a, b, r);
      wait_done(60, n);
      vectors++;
      if (n != 33) begin
        miscompares++; $display("FAIL rnd_latency[%0d]: got %0d want 33", t, n);
      end
      vectors++;
      if (bus.oChars !== exp || bus.oBusy !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd_frame[%0d]: got busy=%b %h want busy=0 %h", t, bus.oBusy,
                 bus.oChars, exp);
      end
      @(negedge Clock);
      vectors++;
      if (bus.oDone !== 1'b0 || bus.oChars !== exp) begin
        miscompares++;
        $display("FAIL rnd_hold[%0d]: got done=%b %h want done=0 %h", t, bus.oDone,
                 bus.oChars, exp);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [255:0] exp;
    int dones;
    exp = model_frame(16'hBEEF, 16'h0042, 32'd123456);
    dones = 0;
    launch(16'hBEEF, 16'h0042, 32'd123456);
    for (int i = 2; i <= 40; i++) begin
      @(negedge Clock);
      if (i == 5) begin
        bus.iA = 16'h1111; bus.iB = 16'h2222; bus.iResult = 32'd99; bus.iStart = 1'b1;
      end
      if (i == 6) bus.iStart = 1'b0;
      if (bus.oDone === 1'b1) dones++;
    end
    vectors++;
    if (dones != 1) begin
      miscompares++; $display("FAIL ignore_dones: got %0d want 1", dones);
    end
    vectors++;
    if (bus.oChars !== exp || bus.oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_frame: got busy=%b %h want busy=0 %h", bus.oBusy, bus.oChars, exp);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    dones = 0;
    launch(16'hCAFE, 16'h0001, 32'd555);
    for (int i = 2; i <= 10; i++) @(negedge Clock);
    Reset = 1'b0;
    #1;
    vectors++;
    if (bus.oChars !== Spaces || bus.oBusy !== 1'b0 || bus.oDone !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_async: got busy=%b done=%b %h want 0 0 spaces", bus.oBusy,
               bus.oDone, bus.oChars);
    end
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (bus.oDone === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++; $display("FAIL midreset_dones: got %0d want 0", dones);
    end
    vectors++;
    if (bus.oChars !== Spaces) begin
      miscompares++; $display("FAIL midreset_chars: got %h want %h", bus.oChars, Spaces);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0]  a, b;
    logic [31:0]  r;
    logic [255:0] exp;
    int n;
    @(negedge Clock);
    a = 16'($urandom); b = 16'($urandom); r = $urandom;
    bus.iA = a; bus.iB = b; bus.iResult = r; bus.iStart = 1'b1;
    for (int t = 0; t < 3; t++) begin
      exp = model_frame(a, b, r);
      wait_done(60, n);
      vectors++;
      if (n != 34) begin
        miscompares++; $display("FAIL b2b_period[%0d]: got %0d want 34", t, n);
      end
      vectors++;
      if (bus.oChars !== exp) begin
        miscompares++; $display("FAIL b2b_frame[%0d]: got %h want %h", t, bus.oChars, exp);
      end
      a = 16'($urandom); b = 16'($urandom); r = $urandom;
      bus.iA = a; bus.iB = b; bus.iResult = r;
      if (t == 2) bus.iStart = 1'b0;
    end
    repeat (3) @(negedge Clock);
    vectors++;
    if (bus.oBusy !== 1'b0) begin
      miscompares++; $display("FAIL b2b_stop: got busy=%b want 0", bus.oBusy);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_result_formatter.md
# lcd_result_formatter

Builds the 32-character frame shown by the LCD driver from a multiplier transaction: operands A and B (16-bit) and the 32-bit product. Operands are shown in hexadecimal and the product in unsigned decimal. Sits between the IMUL2 multiplier and the LCD driver. It converts binary to BCD sequentially (double-dabble, one bit per cycle) and presents a registered, stable character bus that the LCD driver samples at its refresh point.

## Interface
Parameters:
- none; all widths fixed (16-bit operands, 32-bit result, 32 characters).

Ports:
- Clock  input  1  system clock; all state changes on posedge.
- Reset  input  1  asynchronous, active-low reset; one clock domain.
- iA  input  16  operand A, sampled on accept.
- iB  input  16  operand B, sampled on accept.
- iResult  input  32  product to display, sampled on accept (not checked against iA*iB).
- iStart  input  1  request; accepted on a posedge where iStart=1 and oBusy=0.
- oBusy  output  1  high while a frame is being built.
- oDone  output  1  one-cycle pulse when oChars has just been updated.
- oChars  output  256  ASCII frame; char k (k=0..31) in bits [255-8k : 248-8k]; k=0..15 is line 1, k=16..31 is line 2.

## Operation
Frame layout:
- Line 1 is "A=hhhh B=hhhh" followed by 3 spaces. The hex digits come from iA and iB, MSB nibble first, uppercase. Nibble 0-9 maps to 0x30-0x39; A-F maps to 0x41-0x46.
- Line 2 is "R=" followed by a 10-character decimal field, right-justified, then 4 spaces.
- Decimal field: leading zeros become space (0x20). The rightmost digit is always printed, so a value of 0 shows as "0".
- The maximum result, 4294967295, fits in 10 digits, so there is no overflow case.

FSM states are IDLE, CONVERT and EMIT.
- IDLE: on accept, latch iA, iB and iResult into internal registers; clear the 40-bit BCD accumulator; load the shift register with the result; set the bit counter to 0; go to CONVERT.
- CONVERT:
  - Each cycle, first add 3 to every BCD digit that is ≥5.
  - Then shift {BCD, shift register} left by one.
  - Increment the counter; after the 32nd shift, go to EMIT.
- EMIT:
  - Write the full 256-bit oChars in a single cycle from the latched operands and the BCD digits.
  - Assert oDone for that cycle only.
  - Return to IDLE.

Rules:
- iStart while oBusy=1 is ignored. It is not queued.
- oChars changes only at the EMIT edge, so the LCD driver never sees a partially built frame.
- Input ports may change freely after accept.

## Timing
Reset (Reset=0, asynchronous):
- Forces state IDLE, oBusy=0, oDone=0.
- oChars = 32 spaces (0x20 in every byte).
- Internal registers are cleared.
- Reset takes effect mid-conversion: any frame in progress is discarded, and no oDone follows release.

Latency, with accept at edge E:
- oBusy=1 from E until E+33.
- CONVERT shifts occur at edges E+1 through E+32.
- EMIT occurs at edge E+33: oChars updates, oDone=1 during cycle E+33→E+34, and oBusy=0 after E+33.
- The earliest next accept is edge E+34, giving a throughput of one frame per 34 cycles.

Other rules:
- oDone and oBusy are never high in the same cycle.
- oChars holds its value indefinitely between EMITs.
- Back-to-back: if iStart is held high continuously, frames complete every 34 cycles.

## Test plan
- Reset → oChars=32×0x20, oBusy=0, oDone=0; hold 10 cycles with iStart=0 → nothing changes.
- iA=0x1234, iB=0x00FF, iResult=1188300, pulse iStart → oDone exactly 33 cycles after accept, line 1 "A=1234 B=00FF   ", line 2 "R=   1188300    ".
- iA=0, iB=0, iResult=0 → line 1 "A=0000 B=0000   ", line 2 "R=         0    ".
- iA=0xFFFF, iB=0xFFFF, iResult=0xFFFE0001 → line 1 "A=FFFF B=FFFF   ", line 2 "R=4294836225    "; then iResult=0xFFFFFFFF → "R=4294967295    ".
- Start a frame, pulse iStart with different data at accept+5 → only the first frame is produced, and one oDone occurs in 40 cycles.
- Start a frame, assert Reset=0 at accept+10 for 2 cycles → oChars returns to spaces, and no oDone occurs during the following 40 cycles without a new iStart.
